// File: rtl/mem_arbiter_if.sv
// Pipeline-side (IF/MEM request) and SRAM-pin signals of the memory arbiter.
// master is the arbiter's view; slave is the pipeline/SRAM view.
interface mem_arbiter_if;
  localparam int unsigned DataW = 16;

  // Instruction fetch port
  logic             IfReq;
  logic [DataW-1:0] IfAddr;
  logic [DataW-1:0] IfData;
  logic             IfDone;

  // Load/store port
  logic             MemRead;
  logic             MemWrite;
  logic [DataW-1:0] MemAddr;
  logic [DataW-1:0] MemWData;
  logic [DataW-1:0] MemRData;
  logic             MemDone;

  // Pipeline hold
  logic             Stall;

  // SRAM pins
  logic [DataW-1:0] RamAddr;
  logic [DataW-1:0] RamWData;
  logic [DataW-1:0] RamRData;
  logic             RamEn;
  logic             RamOe;
  logic             RamWe;

  modport master (
    input  IfReq, IfAddr, MemRead, MemWrite, MemAddr, MemWData, RamRData,
    output IfData, IfDone, MemRData, MemDone, Stall,
    output RamAddr, RamWData, RamEn, RamOe, RamWe
  );

  modport slave (
    output IfReq, IfAddr, MemRead, MemWrite, MemAddr, MemWData, RamRData,
    input  IfData, IfDone, MemRData, MemDone, Stall,
    input  RamAddr, RamWData, RamEn, RamOe, RamWe
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one SRAM between instruction fetch and load/store, MEM first,
// stalling the pipeline until every request of the current cycle is served.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  state_e           state_q,     state_d;
  owner_e           owner_q,     owner_d;
  logic             write_q,     write_d;
  logic [CntW-1:0]  cnt_q,       cnt_d;
  logic             if_done_q,   if_done_d;
  logic             mem_done_q,  mem_done_d;
  logic [DataW-1:0] if_data_q,   if_data_d;
  logic [DataW-1:0] mem_rdata_q, mem_rdata_d;
  logic [DataW-1:0] ram_addr_q,  ram_addr_d;
  logic [DataW-1:0] ram_wdata_q, ram_wdata_d;
  logic             ram_en_q,    ram_en_d;
  logic             ram_oe_q,    ram_oe_d;
  logic             ram_we_q,    ram_we_d;

  logic mem_req_c;
  logic mem_pend_c;
  logic if_pend_c;
  logic stall_c;

  // A port is pending until its Done flag is set for this pipeline cycle.
  always_comb begin
    mem_req_c  = bus.MemRead | bus.MemWrite;
    mem_pend_c = mem_req_c & ~mem_done_q;
    if_pend_c  = bus.IfReq & ~if_done_q;
    stall_c    = if_pend_c | mem_pend_c;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_en_q    <= ram_en_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
    end
  end

  // Strobes are registered together with the state, so they are high exactly in ACCESS.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_en_d    = ram_en_q;
    ram_oe_d    = ram_oe_q;
    ram_we_d    = ram_we_q;

    unique case (state_q)
      IDLE: begin
        if (mem_pend_c) begin
          state_d     = ACCESS;
          owner_d     = OWN_MEM;
          write_d     = bus.MemWrite;
          cnt_d       = CntW'(WAIT_CYCLES - 1);
          ram_addr_d  = bus.MemAddr;
          ram_wdata_d = bus.MemWData;
          ram_en_d    = 1'b1;
          ram_oe_d    = ~bus.MemWrite;
          ram_we_d    = bus.MemWrite;
        end else if (if_pend_c) begin
          state_d    = ACCESS;
          owner_d    = OWN_IF;
          write_d    = 1'b0;
          cnt_d      = CntW'(WAIT_CYCLES - 1);
          ram_addr_d = bus.IfAddr;
          ram_en_d   = 1'b1;
          ram_oe_d   = 1'b1;
          ram_we_d   = 1'b0;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          ram_oe_d = 1'b0;
          ram_we_d = 1'b0;
          if (owner_q == OWN_MEM) begin
            mem_done_d = 1'b1;
            if (!write_q) mem_rdata_d = bus.RamRData;
          end else begin
            if_done_d = 1'b1;
            if_data_d = bus.RamRData;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Pipeline advances on this edge: the next cycle's requests start fresh.
    if (!stall_c) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  assign bus.Stall    = stall_c;
  assign bus.IfData   = if_data_q;
  assign bus.IfDone   = if_done_q;
  assign bus.MemRData = mem_rdata_q;
  assign bus.MemDone  = mem_done_q;
  assign bus.RamAddr  = ram_addr_q;
  assign bus.RamWData = ram_wdata_q;
  assign bus.RamEn    = ram_en_q;
  assign bus.RamOe    = ram_oe_q;
  assign bus.RamWe    = ram_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for WAIT_CYCLES=2 plus
// single-fetch sequences on WAIT_CYCLES=1 and WAIT_CYCLES=4 instances.
module tb_mem_arbiter;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  mem_arbiter_if b2 ();
  mem_arbiter_if b1 ();
  mem_arbiter_if b4 ();

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut2 (.Clk(Clk), .Rst(Rst), .bus(b2));
  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.Clk(Clk), .Rst(Rst), .bus(b1));
  mem_arbiter #(.WAIT_CYCLES(4)) u_dut4 (.Clk(Clk), .Rst(Rst), .bus(b4));

  // {Stall, RamEn, RamOe, RamWe, RamAddr, RamWData, IfDone, MemDone, IfData, MemRData}
  typedef logic [69:0] obs_t;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] ram_rdata;
    obs_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t o(logic st, logic en, logic oe, logic we,
                             logic [15:0] addr, logic [15:0] wd,
                             logic ifd, logic md,
                             logic [15:0] ifdata, logic [15:0] mrd);
    return {st, en, oe, we, addr, wd, ifd, md, ifdata, mrd};
  endfunction

  task automatic add(logic rst, logic ifr, logic [15:0] ifa, logic mr, logic mw,
                     logic [15:0] ma, logic [15:0] mwd, logic [15:0] rrd, obs_t exp);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.if_addr = ifa; v.mem_rd = mr; v.mem_wr = mw;
    v.mem_addr = ma; v.mem_wdata = mwd; v.ram_rdata = rrd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(string name, obs_t act, obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t obs2();
    return {b2.Stall, b2.RamEn, b2.RamOe, b2.RamWe, b2.RamAddr, b2.RamWData,
            b2.IfDone, b2.MemDone, b2.IfData, b2.MemRData};
  endfunction

  // Single fetch on the W=1 or W=4 instance; timing derived from w.
  task automatic run_single(int w, logic [15:0] data);
    logic st, en, oe, dn;
    logic [15:0] d, a;
    if (w == 1) begin b1.IfReq = 1'b1; b1.IfAddr = 16'h0010; b1.RamRData = data; end
    else        begin b4.IfReq = 1'b1; b4.IfAddr = 16'h0010; b4.RamRData = data; end
    for (int c = 0; c <= w + 1; c++) begin
      @(negedge Clk);
      if (w == 1) begin st = b1.Stall; en = b1.RamEn; oe = b1.RamOe; dn = b1.IfDone; d = b1.IfData; a = b1.RamAddr; end
      else        begin st = b4.Stall; en = b4.RamEn; oe = b4.RamOe; dn = b4.IfDone; d = b4.IfData; a = b4.RamAddr; end
      check($sformatf("w%0d_c%0d_ctl", w, c), obs_t'({st, en, oe, dn}),
            obs_t'({(c <= w), (c >= 1 && c <= w), (c >= 1 && c <= w), (c == w + 1)}));
      if (c >= 1 && c <= w) check($sformatf("w%0d_c%0d_addr", w, c), obs_t'(a), obs_t'(16'h0010));
      if (c == w + 1) check($sformatf("w%0d_data", w), obs_t'(d), obs_t'(data));
      @(posedge Clk);
      #1;
    end
    if (w == 1) b1.IfReq = 1'b0; else b4.IfReq = 1'b0;
    @(negedge Clk);
    if (w == 1) begin st = b1.Stall; dn = b1.IfDone; end
    else        begin st = b4.Stall; dn = b4.IfDone; end
    check($sformatf("w%0d_clear", w), obs_t'({st, dn}), obs_t'(2'b00));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    b2.IfReq = 0; b2.IfAddr = 0; b2.MemRead = 0; b2.MemWrite = 0;
    b2.MemAddr = 0; b2.MemWData = 0; b2.RamRData = 0;
    b1.IfReq = 0; b1.IfAddr = 0; b1.MemRead = 0; b1.MemWrite = 0;
    b1.MemAddr = 0; b1.MemWData = 0; b1.RamRData = 0;
    b4.IfReq = 0; b4.IfAddr = 0; b4.MemRead = 0; b4.MemWrite = 0;
    b4.MemAddr = 0; b4.MemWData = 0; b4.RamRData = 0;

    // rst ifr ifa     mr mw ma       mwd      rrd        st en oe we addr     wdata    ifd md ifdata   mrdata
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    // single fetch
    add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, o(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, o(1, 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, o(1, 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, o(0, 0, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'hA5A5, 16'h0000));
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hA5A5, 16'h0000));
    // store
    add(0, 0, 16'h0000, 0, 1, 16'h8000, 16'h1234, 16'hFFFF, o(1, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 0, 16'h0000, 0, 1, 16'h8000, 16'h1234, 16'hFFFF, o(1, 1, 0, 1, 16'h8000, 16'h1234, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 0, 16'h0000, 0, 1, 16'h8000, 16'h1234, 16'hFFFF, o(1, 1, 0, 1, 16'h8000, 16'h1234, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 0, 16'h0000, 0, 1, 16'h8000, 16'h1234, 16'hFFFF, o(0, 0, 0, 0, 16'h8000, 16'h1234, 0, 1, 16'hA5A5, 16'h0000));
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h8000, 16'h1234, 0, 0, 16'hA5A5, 16'h0000));
    // fetch and load together: MEM first, then IF, MEM never re-issued
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'h0000, o(1, 0, 0, 0, 16'h8000, 16'h1234, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'hBEEF, o(1, 1, 1, 0, 16'h9000, 16'h0000, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'hBEEF, o(1, 1, 1, 0, 16'h9000, 16'h0000, 0, 0, 16'hA5A5, 16'h0000));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'h0000, o(1, 0, 0, 0, 16'h9000, 16'h0000, 0, 1, 16'hA5A5, 16'hBEEF));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'h0F0F, o(1, 1, 1, 0, 16'h0002, 16'h0000, 0, 1, 16'hA5A5, 16'hBEEF));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'h0F0F, o(1, 1, 1, 0, 16'h0002, 16'h0000, 0, 1, 16'hA5A5, 16'hBEEF));
    add(0, 1, 16'h0002, 1, 0, 16'h9000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h0002, 16'h0000, 1, 1, 16'h0F0F, 16'hBEEF));
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 16'h0F0F, 16'hBEEF));
    // reset in the first ACCESS cycle, request restarts afterwards
    add(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(1, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 16'h0F0F, 16'hBEEF));
    add(1, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(1, 1, 1, 0, 16'h0044, 16'h0000, 0, 0, 16'h0F0F, 16'hBEEF));
    add(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(1, 1, 1, 0, 16'h0044, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(1, 1, 1, 0, 16'h0044, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    add(0, 1, 16'h0044, 0, 0, 16'h0000, 16'h0000, 16'h1111, o(0, 0, 0, 0, 16'h0044, 16'h0000, 1, 0, 16'h1111, 16'h0000));
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, o(0, 0, 0, 0, 16'h0044, 16'h0000, 0, 0, 16'h1111, 16'h0000));

    repeat (2) @(posedge Clk);
    foreach (vecs[i]) begin
      #1;
      Rst         = vecs[i].rst;
      b2.IfReq    = vecs[i].if_req;
      b2.IfAddr   = vecs[i].if_addr;
      b2.MemRead  = vecs[i].mem_rd;
      b2.MemWrite = vecs[i].mem_wr;
      b2.MemAddr  = vecs[i].mem_addr;
      b2.MemWData = vecs[i].mem_wdata;
      b2.RamRData = vecs[i].ram_rdata;
      @(negedge Clk);
      check($sformatf("row%0d", i), obs2(), vecs[i].exp);
      @(posedge Clk);
    end

    #1;
    run_single(1, 16'h5A5A);
    run_single(4, 16'hC3C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 16-bit external SRAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 16-bit pipeline. Runs a multi-cycle SRAM access state machine. Gives MEM priority. Holds the pipeline with a stall signal until every pending request of the current cycle has been served. Sits between the IF/MEM stage logic and the SRAM pins, and drives the stall input of all pipeline registers.

## Interface
- WAIT_CYCLES, default 2: cycles the SRAM strobes are held per access; legal range 1..15.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- IfReq  in  1  IF stage requests an instruction read.
- IfAddr  in  16  fetch address.
- IfData  out  16  fetched instruction, registered.
- IfDone  out  1  fetch for the current pipeline cycle is complete.
- MemRead  in  1  MEM stage load request.
- MemWrite  in  1  MEM stage store request.
  - MemRead and MemWrite are never both high.
- MemAddr  in  16  load/store address.
- MemWData  in  16  store data.
- MemRData  out  16  loaded data, registered.
- MemDone  out  1  MEM access for the current pipeline cycle is complete.
- Stall  out  1  combinational; freezes all pipeline registers while high.
- RamAddr  out  16  SRAM address, registered.
- RamWData  out  16  SRAM write data, registered.
- RamRData  in  16  SRAM read data.
- RamEn  out  1  SRAM chip enable, active-high.
- RamOe  out  1  SRAM output enable, active-high.
- RamWe  out  1  SRAM write enable, active-high.

## Operation
- MemReq = MemRead | MemWrite.
- Stall = (IfReq & ~IfDone) | (MemReq & ~MemDone).
- The pipeline holds IfReq/IfAddr and MemRead/MemWrite/MemAddr/MemWData stable while Stall is high.

States: IDLE and ACCESS.

IDLE:
- If MemReq & ~MemDone: latch MemAddr → RamAddr and MemWData → RamWData, record owner = MEM and the op (read/write), load counter = WAIT_CYCLES-1, go to ACCESS.
- Else if IfReq & ~IfDone: latch IfAddr, owner = IF, op = read, go to ACCESS.
- Else stay in IDLE.
- MEM always wins over IF when both are pending.

ACCESS:
- RamEn = 1 throughout.
- RamOe = 1 for reads, RamWe = 1 for writes; never both.
- Counter decrements each cycle.
- On the cycle the counter is 0:
  - For a read, capture RamRData into IfData or MemRData according to the owner.
  - Set IfDone or MemDone according to the owner.
  - Go to IDLE.
  - A write sets MemDone and leaves MemRData unchanged.

Done flags:
- On any edge where Stall = 0, clear both IfDone and MemDone (the pipeline advances).
- Otherwise a Done flag stays set, so a served request is never re-issued while the other port is still pending.

Data outputs:
- IfData and MemRData hold their value until the next capture for that port.

Strobes outside ACCESS:
- RamEn, RamOe and RamWe are 0.
- RamAddr and RamWData hold their last value.

## Timing
Reset:
- State = IDLE, counter = 0.
- IfDone = MemDone = 0.
- IfData = MemRData = 0, RamAddr = RamWData = 0.
- RamEn = RamOe = RamWe = 0.
- Stall follows its equation; with no requests it is 0.

Single access (request first seen in IDLE at cycle 0, W = WAIT_CYCLES):
- ACCESS occupies cycles 1..W.
- Data and Done are captured at the end of cycle W.
- Stall is high in cycles 0..W and low in cycle W+1.
- Done clears at the end of cycle W+1.

Both ports pending at cycle 0:
- MEM access occupies cycles 1..W.
- IDLE at cycle W+1 starts the IF access.
- IF access occupies cycles W+2..2W+1.
- Stall is high in cycles 0..2W+1 and low in cycle 2W+2.

Other rules:
- There is always exactly one IDLE cycle between consecutive accesses.
- A request that arrives during ACCESS is sampled at the next IDLE.
- Reset during ACCESS aborts the access. Strobes are 0 in the cycle after the reset edge, and no Done flag is set.
- A WAIT_CYCLES value outside 1..15 is unsupported.

## Test plan
- Reset, then IfReq = 1 with IfAddr = 0x0010, RamRData = 0xA5A5, W = 2 → RamEn = RamOe = 1 in cycles 1-2, IfData = 0xA5A5 and IfDone = 1 from cycle 3, Stall low in cycle 3, IfDone = 0 in cycle 4.
- MemWrite = 1, MemAddr = 0x8000, MemWData = 0x1234 → RamWe = 1 with RamAddr = 0x8000 and RamWData = 0x1234 for 2 cycles, RamOe = 0, MemRData unchanged, Stall low in cycle 3.
- IfReq and MemRead both high at cycle 0 (IfAddr = 0x0002, MemAddr = 0x9000) → RamAddr = 0x9000 in cycles 1-2, then 0x0002 in cycles 4-5, Stall high in cycles 0-5 and low in cycle 6, IfDone and MemDone both 1 in cycle 6.
- While the IF access is in progress, check that MEM is not re-issued: RamAddr never returns to 0x9000 after cycle 2.
- Assert Rst in cycle 1 of an ACCESS → all strobes 0 in cycle 2, state IDLE, Done flags 0; the still-asserted request restarts from cycle 2.
- Rerun the single-fetch case with WAIT_CYCLES = 1 → IfDone = 1 and Stall low in cycle 2.
- Rerun the single-fetch case with WAIT_CYCLES = 4 → IfDone = 1 and Stall low in cycle 5.
